// File: rtl/park_pkg.sv
// Exit-park shared definitions: FSM states, slot/map widths, gate timing default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package park_pkg;

  localparam int SLOT_W            = 3;
  localparam int MAP_W             = 8;
  localparam int CNT_W             = 4;
  localparam int GATE_CYCLES_DFLT  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/exit_park_slot_popcount.sv
// Counts the free (zero) slots in an occupancy map.
// Latency: combinational.
// Backpressure: none.
// Ports: map - occupancy map (1 = occupied); zero_count - number of zero bits (0..8).
module slot_popcount
  import park_pkg::*;
(
  input  logic [MAP_W-1:0] map,
  output logic [CNT_W-1:0] zero_count
);

  always_comb begin
    zero_count = '0;
    for (int i = 0; i < MAP_W; i++) begin
      zero_count = zero_count + {{(CNT_W-1){1'b0}}, ~map[i]};
    end
  end

endmodule

// File: rtl/exit_park.sv
// Exit barrier controller: clears the vacated slot, opens the gate, flags exits from empty slots.
// Latency: exit sampled at edge N -> update/error after edge N+1, gate_open rises at edge N+2.
// Backpressure: a held exit is processed once; inputs are ignored until the FSM is back in IDLE.
// Ports: clk, rst_n (sync, active-low); exit/park_number/parking_capacity request inputs;
//        parking_capacity_next/free_count registered result, update/error one-cycle pulses,
//        gate_open barrier drive, busy = not IDLE.
module exit_park
  import park_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DFLT
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exit,
  input  logic [SLOT_W-1:0] park_number,
  input  logic [MAP_W-1:0]  parking_capacity,
  output logic [MAP_W-1:0]  parking_capacity_next,
  output logic              update,
  output logic              gate_open,
  output logic              error,
  output logic              busy,
  output logic [CNT_W-1:0]  free_count
);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot_q;
  logic [MAP_W-1:0]  map_q;
  logic [CNT_W-1:0]  gate_cnt;
  logic              slot_hit;
  logic [MAP_W-1:0]  cleared_map;
  logic [CNT_W-1:0]  cleared_free;
  logic              capture_en;
  logic              load_en;
  logic              err_en;

  assign slot_hit    = map_q[slot_q];
  assign cleared_map = map_q & ~(MAP_W'(1) << slot_q);

  // Free count is computed on the value being loaded so it lands with the map.
  slot_popcount u_popcount (
    .map        (cleared_map),
    .zero_count (cleared_free)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (exit) state_nxt = CHECK;
      CHECK:   state_nxt = slot_hit ? OPEN : RELEASE;
      // Counter runs out one cycle after the last gate-high cycle was registered.
      OPEN:    if (gate_cnt == '0) state_nxt = RELEASE;
      RELEASE: if (!exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy       = (state != IDLE);
    capture_en = (state == IDLE) && exit;
    load_en    = (state == CHECK) && slot_hit;
    err_en     = (state == CHECK) && !slot_hit;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q                <= '0;
      map_q                 <= '0;
      parking_capacity_next <= '0;
      free_count            <= CNT_W'(MAP_W);
      update                <= 1'b0;
      error                 <= 1'b0;
      gate_open             <= 1'b0;
      gate_cnt              <= '0;
    end else begin
      update <= load_en;
      error  <= err_en;
      if (capture_en) begin
        slot_q <= park_number;
        map_q  <= parking_capacity;
      end
      if (load_en) begin
        parking_capacity_next <= cleared_map;
        free_count            <= cleared_free;
      end
      // gate_open is registered, so it rises one edge after OPEN is entered
      // and stays high for exactly GATE_CYCLES cycles.
      if (load_en) begin
        gate_cnt  <= CNT_W'(GATE_CYCLES);
        gate_open <= 1'b0;
      end else if ((state == OPEN) && (gate_cnt != '0)) begin
        gate_cnt  <= gate_cnt - 1'b1;
        gate_open <= 1'b1;
      end else begin
        gate_open <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exit_park.sv
// Randomized and directed bench for exit_park against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_exit_park;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       exit;
  logic [2:0] park_number;
  logic [7:0] parking_capacity;
  logic [7:0] parking_capacity_next;
  logic       update;
  logic       gate_open;
  logic       error;
  logic       busy;
  logic [3:0] free_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_next;

  always #5 clk = ~clk;

  exit_park #(.GATE_CYCLES(G)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .exit                  (exit),
    .park_number           (park_number),
    .parking_capacity      (parking_capacity),
    .parking_capacity_next (parking_capacity_next),
    .update                (update),
    .gate_open             (gate_open),
    .error                 (error),
    .busy                  (busy),
    .free_count            (free_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] free_of(input logic [7:0] m);
    return 32'(8 - $countones(m));
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One exit transaction. After edge N the request inputs are overwritten
  // (park_number = alt_slot, random map) to show they are ignored.
  task automatic do_exit(input string tag, input logic [7:0] cap, input logic [2:0] slot,
                         input int hold, input logic [2:0] alt_slot);
    int upd_n = 0, err_n = 0, gate_n = 0;
    int upd_k = -1, err_k = -1, gate_k = -1, idle_k = -1;
    logic hit;
    logic [7:0] exp_nx;
    wait_idle();
    hit    = cap[slot];
    exp_nx = hit ? (cap & ~(8'h01 << slot)) : model_next;
    exit = 1'b1; park_number = slot; parking_capacity = cap;
    @(posedge clk);                     // edge N
    @(negedge clk);
    exit = (hold > 1); park_number = alt_slot; parking_capacity = 8'($urandom);
    for (int k = 1; k <= hold + G + 8; k++) begin
      @(posedge clk);                   // edge N+k
      @(negedge clk);
      if (update)    begin upd_n++;  if (upd_k  < 0) upd_k  = k; end
      if (error)     begin err_n++;  if (err_k  < 0) err_k  = k; end
      if (gate_open) begin gate_n++; if (gate_k < 0) gate_k = k; end
      if (!busy && idle_k < 0) idle_k = k;
      exit = (k + 1 < hold);
      parking_capacity = 8'($urandom);
    end
    check({tag, "_upd_cnt"},  32'(upd_n),  hit ? 32'd1 : 32'd0);
    check({tag, "_err_cnt"},  32'(err_n),  hit ? 32'd0 : 32'd1);
    check({tag, "_gate_cnt"}, 32'(gate_n), hit ? 32'(G) : 32'd0);
    if (hit) begin
      check({tag, "_upd_lat"},  32'(upd_k),  32'd1);
      check({tag, "_gate_lat"}, 32'(gate_k), 32'd2);
    end else begin
      check({tag, "_err_lat"},  32'(err_k),  32'd1);
    end
    check({tag, "_next"}, 32'(parking_capacity_next), 32'(exp_nx));
    check({tag, "_free"}, 32'(free_count), free_of(exp_nx));
    check({tag, "_busy_held"}, 32'(idle_k >= hold), 32'd1);
    model_next = exp_nx;
  endtask

  initial begin
    rst_n = 1'b0; exit = 1'b0; park_number = '0; parking_capacity = '0;
    model_next = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_next",   32'(parking_capacity_next), 32'h00);
    check("rst_free",   32'(free_count), 32'd8);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_gate",   32'(gate_open), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_error",  32'(error), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_exit("a0_s5",   8'hA0, 3'd5, 1,  3'd5);
    do_exit("err_s0",  8'h20, 3'd0, 1,  3'd0);
    do_exit("ff_s7",   8'hFF, 3'd7, 20, 3'd7);
    do_exit("chg_3_6", 8'h48, 3'd3, 2,  3'd6);

    // Reset on the second OPEN cycle
    wait_idle();
    exit = 1'b1; park_number = 3'd2; parking_capacity = 8'h04;
    @(posedge clk); @(negedge clk);     // after edge N
    exit = 1'b0;
    @(posedge clk); @(negedge clk);     // after N+1: OPEN entered
    check("mid_upd", 32'(update), 32'd1);
    @(posedge clk); @(negedge clk);     // after N+2: first gate cycle
    check("mid_gate_on", 32'(gate_open), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_gate", 32'(gate_open), 32'd0);
    check("mid_rst_next", 32'(parking_capacity_next), 32'h00);
    check("mid_rst_free", 32'(free_count), 32'd8);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    model_next = 8'h00;
    begin
      int g = 0;
      int u = 0;
      repeat (G + 4) begin
        @(posedge clk); @(negedge clk);
        if (gate_open) g++;
        if (update) u++;
      end
      check("post_rst_gate", 32'(g), 32'd0);
      check("post_rst_upd",  32'(u), 32'd0);
    end

    // Back-to-back exits, exit dropped between them
    do_exit("b2b_1", 8'hA0, 3'd5, 1, 3'd1);
    do_exit("b2b_2", 8'h80, 3'd7, 1, 3'd0);
    check("b2b_final_free", 32'(free_count), 32'd8);

    for (int i = 0; i < 30; i++) begin
      do_exit("rnd", 8'($urandom), 3'($urandom_range(0, 7)),
              int'($urandom_range(1, 20)), 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
